// File: rtl/vx_imem_responder_pkg.sv
// Shared instruction-cache bus constants and helpers for vx_imem_responder.
// Optional performance counters are enabled with the IMEM_RESPONDER_PERF_EN macro.
package vx_imem_responder_pkg;

   localparam int ICACHE_ADDR_WIDTH  = 30;
   localparam int ICACHE_TAG_WIDTH   = 46;
   localparam int ICACHE_WORD_SIZE   = 4;
   // Low tag bits carry the warp id; the responder never looks at them.
   localparam int ICACHE_TAG_ID_BITS = 2;

   // Width of a counter that must hold every value 0..depth inclusive.
   function automatic int credit_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/vx_imem_responder_if.sv
// Instruction-cache request/response bus between the fetch stage (master)
// and a memory responder (slave).
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// a response transfers on a rising edge where rsp_valid && rsp_ready. A source
// holding valid high keeps its payload stable until the transfer happens, and
// valid never depends combinationally on the matching ready.
interface vx_imem_responder_if #(
   parameter int ADDR_WIDTH = vx_imem_responder_pkg::ICACHE_ADDR_WIDTH,
   parameter int TAG_WIDTH  = vx_imem_responder_pkg::ICACHE_TAG_WIDTH,
   parameter int WORD_SIZE  = vx_imem_responder_pkg::ICACHE_WORD_SIZE
) ();
   import vx_imem_responder_pkg::*;

   logic                   req_valid;
   logic                   req_ready;
   logic                   req_rw;
   logic [ADDR_WIDTH-1:0]  req_addr;
   logic [WORD_SIZE-1:0]   req_byteen;
   logic [8*WORD_SIZE-1:0] req_data;
   logic [TAG_WIDTH-1:0]   req_tag;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [8*WORD_SIZE-1:0] rsp_data;
   logic [TAG_WIDTH-1:0]   rsp_tag;

   modport master (
      output req_valid, req_rw, req_addr, req_byteen, req_data, req_tag, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_tag
   );

   modport slave (
      input  req_valid, req_rw, req_addr, req_byteen, req_data, req_tag, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_tag
   );

endinterface

// File: rtl/vx_imem_rsp_queue.sv
// Response FIFO of {data, tag} entries with a registered head and no bypass:
// an entry pushed on one edge is visible at the head from the next cycle on.
module vx_imem_rsp_queue
   import vx_imem_responder_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 46,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic [TAG_WIDTH-1:0]  push_tag,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic [TAG_WIDTH-1:0]  head_tag,
   output logic                  empty,
   output logic                  full
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = credit_width(DEPTH);
   localparam int ENTRY_W = DATA_WIDTH + TAG_WIDTH;
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [ENTRY_W-1:0] slots [DEPTH];
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [CNT_W-1:0]   count;
   logic               do_push;
   logic               do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop && !empty;
   // A push into a full queue is only taken when a pop frees a slot this cycle.
   assign do_push = push && (!full || do_pop);

   assign {head_data, head_tag} = slots[rd_ptr];

   // Entry storage: written at the tail, never reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         slots[wr_ptr] <= {push_data, push_tag};
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/vx_imem_responder.sv
// Instruction-cache bus responder: local word memory with byte-enabled writes,
// fixed-latency reads and an in-order, credit-limited response queue.
// Optional perf counters (perf_reads/perf_writes/perf_stalls) are enabled by
// defining IMEM_RESPONDER_PERF_EN.
module vx_imem_responder
  import vx_imem_responder_pkg::*;
#(
  parameter int    ADDR_WIDTH     = ICACHE_ADDR_WIDTH,
  parameter int    TAG_WIDTH      = ICACHE_TAG_WIDTH,
  parameter int    WORD_SIZE      = ICACHE_WORD_SIZE,
  parameter int    MEM_WORDS_LOG2 = 12,
  parameter int    LATENCY        = 2,
  parameter int    RSP_QUEUE_SIZE = 4,
  parameter string INIT_FILE      = ""
) (
  input  logic               clk,
  input  logic               reset,
  vx_imem_responder_if.slave bus
`ifdef IMEM_RESPONDER_PERF_EN
  ,
  output logic [31:0]        perf_reads,
  output logic [31:0]        perf_writes,
  output logic [31:0]        perf_stalls
`endif
);

  localparam int DATA_W    = 8 * WORD_SIZE;
  localparam int MEM_WORDS = 1 << MEM_WORDS_LOG2;
  localparam int CNT_W     = credit_width(RSP_QUEUE_SIZE);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CREDITS = CNT_W'(RSP_QUEUE_SIZE);

  logic [DATA_W-1:0]         mem [MEM_WORDS];
  logic [ADDR_WIDTH-1:0]     addr;
  logic [MEM_WORDS_LOG2-1:0] idx;
  logic                      unused_addr_bits;
  logic [DATA_W-1:0]         mem_rd_data;

  logic             ready_q;
  logic [CNT_W-1:0] pending;
  logic [CNT_W-1:0] pending_next;
  logic             rd_fire;
  logic             wr_fire;
  logic             rsp_fire;

  logic                 push_valid;
  logic [DATA_W-1:0]    push_data;
  logic [TAG_WIDTH-1:0] push_tag;
  logic                 q_empty;
  logic                 q_full;

  // Upper address bits do not select anything: indices wrap modulo the depth.
  assign addr             = bus.req_addr;
  assign idx              = addr[MEM_WORDS_LOG2-1:0];
  assign unused_addr_bits = &{1'b0, addr[ADDR_WIDTH-1:MEM_WORDS_LOG2], q_full};

  assign rd_fire  = bus.req_valid && ready_q && !bus.req_rw;
  assign wr_fire  = bus.req_valid && ready_q &&  bus.req_rw;
  assign rsp_fire = bus.rsp_valid && bus.rsp_ready;

  assign bus.req_ready = ready_q;

  // Byte-enabled word write; memory keeps its contents through reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < WORD_SIZE; b++) begin
        if (bus.req_byteen[b]) begin
          mem[idx][8*b +: 8] <= bus.req_data[8*b +: 8];
        end
      end
    end
  end

  // The read is taken at the edge ending the accept cycle.
  assign mem_rd_data = mem[idx];

  // Outstanding-read credit: one per read in the pipeline or the queue.
  always_comb begin
    pending_next = pending;
    if (rd_fire && !rsp_fire) begin
      pending_next = pending + CNT_ONE;
    end else if (!rd_fire && rsp_fire) begin
      pending_next = pending - CNT_ONE;
    end
  end

  // Credit register; req_ready is registered so it never sees rsp_ready or req_valid combinationally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending <= '0;
      ready_q <= 1'b0;
    end else begin
      pending <= pending_next;
      ready_q <= (pending_next != CREDITS);
    end
  end

  generate
    if (LATENCY == 1) begin : g_no_pipe
      // Single-cycle latency: the read result goes straight into the queue.
      assign push_valid = rd_fire;
      assign push_data  = mem_rd_data;
      assign push_tag   = bus.req_tag;
    end else begin : g_pipe
      logic [LATENCY-2:0]   stg_valid;
      logic [DATA_W-1:0]    stg_data [LATENCY-1];
      logic [TAG_WIDTH-1:0] stg_tag  [LATENCY-1];

      // Valid shift chain; cleared by reset so in-flight reads are dropped.
      always_ff @(posedge clk) begin
        if (!reset) begin
          stg_valid <= '0;
        end else begin
          stg_valid[0] <= rd_fire;
          for (int i = 1; i < LATENCY - 1; i++) begin
            stg_valid[i] <= stg_valid[i-1];
          end
        end
      end

      // Data/tag shift chain that follows the valids; no reset needed.
      always_ff @(posedge clk) begin
        stg_data[0] <= mem_rd_data;
        stg_tag[0]  <= bus.req_tag;
        for (int i = 1; i < LATENCY - 1; i++) begin
          stg_data[i] <= stg_data[i-1];
          stg_tag[i]  <= stg_tag[i-1];
        end
      end

      assign push_valid = stg_valid[LATENCY-2];
      assign push_data  = stg_data[LATENCY-2];
      assign push_tag   = stg_tag[LATENCY-2];
    end
  endgenerate

  // The credit limit guarantees a slot for every push, so the pipeline never stalls.
  vx_imem_rsp_queue #(
    .DATA_WIDTH (DATA_W),
    .TAG_WIDTH  (TAG_WIDTH),
    .DEPTH      (RSP_QUEUE_SIZE)
  ) u_rsp_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push_valid),
    .push_data (push_data),
    .push_tag  (push_tag),
    .pop       (bus.rsp_ready),
    .head_data (bus.rsp_data),
    .head_tag  (bus.rsp_tag),
    .empty     (q_empty),
    .full      (q_full)
  );

  assign bus.rsp_valid = !q_empty;

`ifdef IMEM_RESPONDER_PERF_EN
  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_reads  <= '0;
      perf_writes <= '0;
      perf_stalls <= '0;
    end else begin
      if (rd_fire) perf_reads  <= perf_reads + 32'd1;
      if (wr_fire) perf_writes <= perf_writes + 32'd1;
      if (bus.req_valid && !ready_q) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vx_imem_responder.sv
// Bench for vx_imem_responder: directed vector table, hand sequences for
// back-pressure, burst throughput and reset, then randomized traffic against
// a queue-based reference model.
module tb_vx_imem_responder;
   import vx_imem_responder_pkg::*;

   localparam int AW  = 30;
   localparam int TW  = 46;
   localparam int WS  = 4;
   localparam int DW  = 32;
   localparam int MWL = 12;
   localparam int LAT = 2;
   localparam int QS  = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   vx_imem_responder_if #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW), .WORD_SIZE(WS)) bus ();

`ifdef IMEM_RESPONDER_PERF_EN
   logic [31:0] perf_reads, perf_writes, perf_stalls;
`endif

   vx_imem_responder #(
      .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .WORD_SIZE(WS),
      .MEM_WORDS_LOG2(MWL), .LATENCY(LAT), .RSP_QUEUE_SIZE(QS), .INIT_FILE("")
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef IMEM_RESPONDER_PERF_EN
      ,
      .perf_reads  (perf_reads),
      .perf_writes (perf_writes),
      .perf_stalls (perf_stalls)
`endif
   );

   // ---------------- reference model / scoreboard ----------------
   logic [DW-1:0]    ref_mem [1 << MWL];
   logic [DW+TW-1:0] exp_q[$];     // {data, tag} in request order
   int               exp_rdy_q[$]; // earliest cycle each response may appear
   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int pops = 0;
   int not_ready_cycles = 0;
   int n_rd = 0;
   int n_wr = 0;
   int n_stall = 0;
   logic [DW-1:0] last_pop_data;
   logic [TW-1:0] last_pop_tag;
   int            last_pop_cyc;
   logic [TW-1:0] pop_tags[$];

   typedef struct {
      bit            rw;
      logic [AW-1:0] addr;
      logic [WS-1:0] be;
      logic [DW-1:0] data;
      logic [TW-1:0] tag;
      logic [DW-1:0] exp_data;
   } vec_t;

   vec_t vecs[16];

   task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // One bus cycle: drive inputs, check registered outputs against the model,
   // update the model with what the cycle transfers, then advance.
   task automatic step(input bit v, input bit rw, input logic [AW-1:0] addr,
                       input logic [WS-1:0] be, input logic [DW-1:0] data,
                       input logic [TW-1:0] tag, input bit rr);
      bit               exp_ready;
      bit               exp_valid;
      logic [DW+TW-1:0] head;
      int               idx;
      bus.req_valid  = v;
      bus.req_rw     = rw;
      bus.req_addr   = addr;
      bus.req_byteen = be;
      bus.req_data   = data;
      bus.req_tag    = tag;
      bus.rsp_ready  = rr;
      exp_ready = (exp_q.size() < QS);
      exp_valid = 1'b0;
      head = '0;
      if (exp_q.size() > 0) begin
         head = exp_q[0];
         exp_valid = (exp_rdy_q[0] <= cyc);
      end
      check_val("req_ready", 64'(bus.req_ready), 64'(exp_ready));
      check_val("rsp_valid", 64'(bus.rsp_valid), 64'(exp_valid));
      if (exp_valid) begin
         check_val("rsp_data", 64'(bus.rsp_data), 64'(head[TW +: DW]));
         check_val("rsp_tag", 64'(bus.rsp_tag), 64'(head[TW-1:0]));
      end
      if (!bus.req_ready) not_ready_cycles++;
      if (bus.rsp_valid && rr) begin
         pops++;
         last_pop_data = bus.rsp_data;
         last_pop_tag  = bus.rsp_tag;
         last_pop_cyc  = cyc;
         pop_tags.push_back(bus.rsp_tag);
      end
      if (exp_valid && rr) begin
         void'(exp_q.pop_front());
         void'(exp_rdy_q.pop_front());
      end
      if (v && !exp_ready) n_stall++;
      if (v && exp_ready) begin
         idx = int'(addr[MWL-1:0]);
         if (rw) begin
            n_wr++;
            for (int b = 0; b < WS; b++) begin
               if (be[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
            end
         end else begin
            n_rd++;
            exp_q.push_back({ref_mem[idx], tag});
            exp_rdy_q.push_back(cyc + LAT);
         end
      end
      tick();
   endtask

   task automatic idle(input bit rr);
      step(1'b0, 1'b0, '0, '0, '0, '0, rr);
   endtask

   task automatic do_reset(input int n);
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b0;
      reset = 1'b0;
      tick();
      check_val("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      check_val("rst_req_ready", 64'(bus.req_ready), 64'(0));
      repeat (n - 1) tick();
      check_val("rst_hold_ready", 64'(bus.req_ready), 64'(0));
      reset = 1'b1;
      tick();
      exp_q.delete();
      exp_rdy_q.delete();
      n_rd = 0;
      n_wr = 0;
      n_stall = 0;
      check_val("rel_req_ready", 64'(bus.req_ready), 64'(1));
      check_val("rel_rsp_valid", 64'(bus.rsp_valid), 64'(0));
   endtask

   // Issue a single read and wait (bounded) for its response.
   task automatic read_one(input logic [AW-1:0] addr, input logic [TW-1:0] tag,
                           input logic [DW-1:0] exp_data, input string name);
      int p0;
      int acc;
      p0  = pops;
      acc = cyc;
      step(1'b0 | 1'b1, 1'b0, addr, '0, '0, tag, 1'b1);
      for (int k = 0; k < 10 && pops == p0; k++) idle(1'b1);
      if (pops == p0) begin
         check_val({name, "_timeout"}, 64'(0), 64'(1));
      end else begin
         check_val({name, "_data"}, 64'(last_pop_data), 64'(exp_data));
         check_val({name, "_tag"}, 64'(last_pop_tag), 64'(tag));
         check_val({name, "_latency"}, 64'(last_pop_cyc - acc), 64'(LAT));
      end
   endtask

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0]   r64;
      logic [31:0]   r32;
      logic [AW-1:0] a;
      int            p0;
      int            nr0;
      int            bad;

      bus.req_valid  = 1'b0;
      bus.req_rw     = 1'b0;
      bus.req_addr   = '0;
      bus.req_byteen = '0;
      bus.req_data   = '0;
      bus.req_tag    = '0;
      bus.rsp_ready  = 1'b0;

      vecs[0]  = '{1'b1, 30'h10,       4'hF, 32'hDEADBEEF, 46'h0,          32'h0};
      vecs[1]  = '{1'b0, 30'h10,       4'h0, 32'h0,        46'h3,          32'hDEADBEEF};
      vecs[2]  = '{1'b1, 30'h20,       4'hF, 32'h11223344, 46'h0,          32'h0};
      vecs[3]  = '{1'b1, 30'h20,       4'h2, 32'h0000AA00, 46'h0,          32'h0};
      vecs[4]  = '{1'b0, 30'h20,       4'h0, 32'h0,        46'h5,          32'h1122AA44};
      vecs[5]  = '{1'b1, 30'h20,       4'h0, 32'hFFFFFFFF, 46'h0,          32'h0};
      vecs[6]  = '{1'b0, 30'h20,       4'h0, 32'h0,        46'h6,          32'h1122AA44};
      vecs[7]  = '{1'b0, 30'h1010,     4'h0, 32'h0,        46'h7,          32'hDEADBEEF};
      vecs[8]  = '{1'b1, 30'h2030,     4'hF, 32'hCAFEF00D, 46'h0,          32'h0};
      vecs[9]  = '{1'b0, 30'h030,      4'h0, 32'h0,        46'h3FFFFFFFFFFF, 32'hCAFEF00D};
      vecs[10] = '{1'b1, 30'h40,       4'hF, 32'h00000000, 46'h0,          32'h0};
      vecs[11] = '{1'b1, 30'h40,       4'h9, 32'hAB0000CD, 46'h0,          32'h0};
      vecs[12] = '{1'b0, 30'h40,       4'h0, 32'h0,        46'h123456789AB, 32'hAB0000CD};
      vecs[13] = '{1'b1, 30'h3FFFF010, 4'hF, 32'h600DF00D, 46'h0,          32'h0};
      vecs[14] = '{1'b0, 30'h10,       4'h0, 32'h0,        46'h1,          32'h600DF00D};
      vecs[15] = '{1'b1, 30'h10,       4'hF, 32'hDEADBEEF, 46'h0,          32'h0};

      do_reset(3);

      // ---- directed vector table ----
      for (int i = 0; i < 16; i++) begin
         if (vecs[i].rw) begin
            step(1'b1, 1'b1, vecs[i].addr, vecs[i].be, vecs[i].data, '0, 1'b1);
         end else begin
            read_one(vecs[i].addr, vecs[i].tag, vecs[i].exp_data, $sformatf("vec%0d", i));
         end
      end

      // ---- back-pressure: four reads with rsp_ready low ----
      pop_tags.delete();
      p0 = pops;
      for (int t = 0; t < 4; t++) begin
         step(1'b1, 1'b0, AW'(16 * (t + 1)), '0, '0, TW'(t), 1'b0);
      end
      check_val("bp_ready_low", 64'(bus.req_ready), 64'(0));
      step(1'b1, 1'b0, 30'h10, '0, '0, 46'h99, 1'b0); // must not be accepted
      idle(1'b0);
      check_val("bp_head_stable", 64'(bus.rsp_tag), 64'(0));
      check_val("bp_head_valid", 64'(bus.rsp_valid), 64'(1));
      for (int k = 0; k < 12 && (pops - p0) < 4; k++) begin
         idle(1'b1);
         if (pops - p0 == 1 && k == 0) begin
            check_val("bp_ready_after_pop", 64'(bus.req_ready), 64'(1));
         end
      end
      check_val("bp_pop_count", 64'(pops - p0), 64'(4));
      bad = 0;
      for (int t = 0; t < pop_tags.size() && t < 4; t++) begin
         if (pop_tags[t] !== TW'(t)) bad++;
      end
      check_val("bp_tag_order", 64'(bad), 64'(0));

      // ---- known contents for indices 0..15 ----
      for (int i = 0; i < 16; i++) begin
         r32 = $urandom();
         step(1'b1, 1'b1, AW'(i), 4'hF, r32, '0, 1'b1);
      end

      // ---- sustained reads with rsp_ready high ----
      pop_tags.delete();
      p0  = pops;
      nr0 = not_ready_cycles;
      for (int i = 0; i < 100; i++) begin
         step(1'b1, 1'b0, AW'(i % 16), '0, '0, TW'(1000 + i), 1'b1);
      end
      for (int k = 0; k < 10 && (pops - p0) < 100; k++) idle(1'b1);
      check_val("burst_count", 64'(pops - p0), 64'(100));
      check_val("burst_no_stall", 64'(not_ready_cycles - nr0), 64'(0));
      bad = 0;
      for (int i = 0; i < pop_tags.size(); i++) begin
         if (pop_tags[i] !== TW'(1000 + i)) bad++;
      end
      check_val("burst_tag_order", 64'(bad), 64'(0));

      // ---- reset with three reads outstanding ----
      for (int t = 0; t < 3; t++) begin
         step(1'b1, 1'b0, 30'h10, '0, '0, TW'(7 + t), 1'b0);
      end
      idle(1'b0);
      p0 = pops;
      do_reset(2);
      for (int k = 0; k < 10; k++) idle(1'b1);
      check_val("no_stale_rsp", 64'(pops - p0), 64'(0));
      read_one(30'h10, 46'h55, 32'hDEADBEEF, "mem_kept");

      // ---- randomized traffic against the model ----
      for (int i = 0; i < 500; i++) begin
         r32 = $urandom();
         a   = r32[AW-1:0];
         a[MWL-1:0] = MWL'($urandom_range(0, 15));
         r64 = {$urandom(), $urandom()};
         r32 = $urandom();
         step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, a,
              WS'($urandom_range(0, 15)), r32, r64[TW-1:0], $urandom_range(0, 9) < 6);
      end
      for (int k = 0; k < 20; k++) idle(1'b1);
      check_val("drain_empty", 64'(bus.rsp_valid), 64'(0));
      check_val("drain_ready", 64'(bus.req_ready), 64'(1));

`ifdef IMEM_RESPONDER_PERF_EN
      check_val("perf_reads", 64'(perf_reads), 64'(n_rd));
      check_val("perf_writes", 64'(perf_writes), 64'(n_wr));
      check_val("perf_stalls", 64'(perf_stalls), 64'(n_stall));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
